// File: rtl/gps_ca_signal_gen.sv
// Baseband GPS L1 C/A BPSK sample generator for one PRN with a one-entry nav-bit buffer.

package gps_math_pkg;
   // Q8.8 signed fixed-point sample
   typedef logic signed [15:0] fxp_t;
endpackage

module gps_ca_signal_gen #(
   parameter int unsigned CODE_NCO_W    = 32,
   parameter int unsigned CODES_PER_BIT = 20,
   parameter logic [15:0] AMPLITUDE     = 16'h0100
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_i,
   input  logic [5:0]            prn_sel_i,
   input  logic [CODE_NCO_W-1:0] code_fcw_i,
   input  logic                  nav_bit_i,
   input  logic                  nav_valid_i,
   output logic                  nav_ready_o,
   output gps_math_pkg::fxp_t    sample_o,
   output logic                  sample_valid_o,
   output logic                  chip_o,
   output logic                  epoch_o,
   output logic                  bit_edge_o,
   output logic                  underrun_o
);

   localparam int unsigned LFSR_W   = 10;
   localparam int unsigned CNT_W    = (CODES_PER_BIT > 1) ? $clog2(CODES_PER_BIT) : 1;
   localparam logic [9:0]  LAST_CHIP = 10'd1022;
   localparam logic [15:0] AMP_POS  = AMPLITUDE;
   localparam logic [15:0] AMP_NEG  = 16'(~AMPLITUDE + 16'd1);

   typedef enum logic [1:0] {IDLE, FETCH, RUN} state_t;

   // G2 tap pair (1-based stage numbers) for each PRN
   function automatic logic [7:0] prn_taps(input logic [5:0] prn);
      case (prn)
         6'd1:  return {4'd2, 4'd6};
         6'd2:  return {4'd3, 4'd7};
         6'd3:  return {4'd4, 4'd8};
         6'd4:  return {4'd5, 4'd9};
         6'd5:  return {4'd1, 4'd9};
         6'd6:  return {4'd2, 4'd10};
         6'd7:  return {4'd1, 4'd8};
         6'd8:  return {4'd2, 4'd9};
         6'd9:  return {4'd3, 4'd10};
         6'd10: return {4'd2, 4'd3};
         6'd11: return {4'd3, 4'd4};
         6'd12: return {4'd5, 4'd6};
         6'd13: return {4'd6, 4'd7};
         6'd14: return {4'd7, 4'd8};
         6'd15: return {4'd8, 4'd9};
         6'd16: return {4'd9, 4'd10};
         6'd17: return {4'd1, 4'd4};
         6'd18: return {4'd2, 4'd5};
         6'd19: return {4'd3, 4'd6};
         6'd20: return {4'd4, 4'd7};
         6'd21: return {4'd5, 4'd8};
         6'd22: return {4'd6, 4'd9};
         6'd23: return {4'd1, 4'd3};
         6'd24: return {4'd4, 4'd6};
         6'd25: return {4'd5, 4'd7};
         6'd26: return {4'd6, 4'd8};
         6'd27: return {4'd7, 4'd9};
         6'd28: return {4'd8, 4'd10};
         6'd29: return {4'd1, 4'd6};
         6'd30: return {4'd2, 4'd7};
         6'd31: return {4'd3, 4'd8};
         6'd32: return {4'd4, 4'd9};
         default: return {4'd1, 4'd1};
      endcase
   endfunction

   // chip = G1 stage 10 ^ two G2 stages selected by one-hot masks
   function automatic logic code_chip(input logic [LFSR_W-1:0] g1v, input logic [LFSR_W-1:0] g2v,
                                      input logic [LFSR_W-1:0] mi, input logic [LFSR_W-1:0] mj);
      return g1v[9] ^ (|(g2v & mi)) ^ (|(g2v & mj));
   endfunction

   state_t                state, state_n;
   logic [CODE_NCO_W-1:0] acc, acc_n;
   logic [CODE_NCO_W:0]   acc_sum;
   logic [LFSR_W-1:0]     g1, g1_n, g2, g2_n;
   logic [LFSR_W-1:0]     mask_i, mask_i_n, mask_j, mask_j_n;
   logic [9:0]            chip_idx, chip_idx_n;
   logic [CNT_W-1:0]      code_cnt, code_cnt_n;
   logic                  buf_full, buf_full_n, buf_bit, buf_bit_n;
   logic                  cur_bit, cur_bit_n;
   logic                  underrun_n, epoch_n, edge_n, valid_n, ready_n, chip_n;
   gps_math_pkg::fxp_t    sample_n;
   logic [7:0]            taps;
   logic                  prn_ok;
   logic                  hs;

   assign acc_sum = {1'b0, acc} + {1'b0, code_fcw_i};
   assign taps    = prn_taps(prn_sel_i);
   assign prn_ok  = (prn_sel_i != 6'd0) && (prn_sel_i <= 6'd32);
   assign hs      = nav_valid_i & nav_ready_o;

   // Next-state, code NCO, LFSR stepping, nav buffer and registered-output values
   always_comb begin
      state_n    = state;
      acc_n      = acc;
      g1_n       = g1;
      g2_n       = g2;
      mask_i_n   = mask_i;
      mask_j_n   = mask_j;
      chip_idx_n = chip_idx;
      code_cnt_n = code_cnt;
      buf_full_n = buf_full;
      buf_bit_n  = buf_bit;
      cur_bit_n  = cur_bit;
      underrun_n = underrun_o;
      epoch_n    = 1'b0;
      edge_n     = 1'b0;

      case (state)
         IDLE: begin
            if (en_i && prn_ok) begin
               state_n    = FETCH;
               mask_i_n   = LFSR_W'(1) << (taps[7:4] - 4'd1);
               mask_j_n   = LFSR_W'(1) << (taps[3:0] - 4'd1);
               acc_n      = '0;
               g1_n       = '1;
               g2_n       = '1;
               chip_idx_n = '0;
               code_cnt_n = '0;
               buf_full_n = 1'b0;
               buf_bit_n  = 1'b0;
               cur_bit_n  = 1'b0;
            end
         end
         FETCH: begin
            if (!en_i) begin
               state_n = IDLE;
            end else if (hs) begin
               state_n   = RUN;
               cur_bit_n = nav_bit_i;
               epoch_n   = 1'b1;
               edge_n    = 1'b1;
            end
         end
         RUN: begin
            if (!en_i) begin
               state_n    = IDLE;
               buf_full_n = 1'b0;
            end else begin
               acc_n = acc_sum[CODE_NCO_W-1:0];
               if (acc_sum[CODE_NCO_W]) begin
                  if (chip_idx == LAST_CHIP) begin
                     chip_idx_n = '0;
                     g1_n       = '1;
                     g2_n       = '1;
                     epoch_n    = 1'b1;
                     if (code_cnt == CNT_W'(CODES_PER_BIT - 1)) begin
                        code_cnt_n = '0;
                        edge_n     = 1'b1;
                     end else begin
                        code_cnt_n = code_cnt + CNT_W'(1);
                     end
                  end else begin
                     chip_idx_n = chip_idx + 10'd1;
                     g1_n = {g1[8:0], g1[2] ^ g1[9]};
                     g2_n = {g2[8:0], g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9]};
                  end
               end
               // nav bit boundary: take buffer, else bypass, else underrun
               if (edge_n) begin
                  if (buf_full) begin
                     cur_bit_n  = buf_bit;
                     buf_full_n = 1'b0;
                  end else if (hs) begin
                     cur_bit_n = nav_bit_i;
                  end else begin
                     cur_bit_n  = 1'b0;
                     underrun_n = 1'b1;
                  end
               end else if (hs) begin
                  buf_full_n = 1'b1;
                  buf_bit_n  = nav_bit_i;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      valid_n  = (state_n == RUN);
      ready_n  = (state_n == FETCH) || ((state_n == RUN) && !buf_full_n);
      chip_n   = valid_n & code_chip(g1_n, g2_n, mask_i_n, mask_j_n);
      sample_n = !valid_n ? '0 : ((chip_n ^ cur_bit_n) ? AMP_NEG : AMP_POS);
   end

   // State, datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         acc            <= '0;
         g1             <= '1;
         g2             <= '1;
         mask_i         <= '0;
         mask_j         <= '0;
         chip_idx       <= '0;
         code_cnt       <= '0;
         buf_full       <= 1'b0;
         buf_bit        <= 1'b0;
         cur_bit        <= 1'b0;
         nav_ready_o    <= 1'b0;
         sample_o       <= '0;
         sample_valid_o <= 1'b0;
         chip_o         <= 1'b0;
         epoch_o        <= 1'b0;
         bit_edge_o     <= 1'b0;
         underrun_o     <= 1'b0;
      end else begin
         state          <= state_n;
         acc            <= acc_n;
         g1             <= g1_n;
         g2             <= g2_n;
         mask_i         <= mask_i_n;
         mask_j         <= mask_j_n;
         chip_idx       <= chip_idx_n;
         code_cnt       <= code_cnt_n;
         buf_full       <= buf_full_n;
         buf_bit        <= buf_bit_n;
         cur_bit        <= cur_bit_n;
         nav_ready_o    <= ready_n;
         sample_o       <= sample_n;
         sample_valid_o <= valid_n;
         chip_o         <= chip_n;
         epoch_o        <= epoch_n;
         bit_edge_o     <= edge_n;
         underrun_o     <= underrun_n;
      end
   end

endmodule

// File: tb/tb_gps_ca_signal_gen.sv
// Randomised bench for gps_ca_signal_gen against a chip-count based reference model.
module tb_gps_ca_signal_gen;

   logic        clk = 1'b0;
   logic        rst, en_i, nav_bit_i, nav_valid_i;
   logic [5:0]  prn_sel_i;
   logic [31:0] code_fcw_i;
   logic        nav_ready_o, sample_valid_o, chip_o, epoch_o, bit_edge_o, underrun_o;
   logic [15:0] sample_o;

   always #5 clk = ~clk;

   gps_ca_signal_gen dut (
      .clk(clk), .rst(rst), .en_i(en_i), .prn_sel_i(prn_sel_i), .code_fcw_i(code_fcw_i),
      .nav_bit_i(nav_bit_i), .nav_valid_i(nav_valid_i), .nav_ready_o(nav_ready_o),
      .sample_o(sample_o), .sample_valid_o(sample_valid_o), .chip_o(chip_o),
      .epoch_o(epoch_o), .bit_edge_o(bit_edge_o), .underrun_o(underrun_o)
   );

   int n_err = 0;
   int n_chk = 0;
   int cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Full C/A code for every PRN, built from the G1/G2 polynomials and tap table
   bit code_tab [1:32][0:1022];
   int tap_a [0:31] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
   int tap_b [0:31] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

   task automatic gen_codes();
      int g1 [1:10];
      int g2 [1:10];
      int f1, f2;
      for (int p = 1; p <= 32; p++) begin
         for (int k = 1; k <= 10; k++) begin g1[k] = 1; g2[k] = 1; end
         for (int i = 0; i < 1023; i++) begin
            code_tab[p][i] = bit'(g1[10] ^ g2[tap_a[p-1]] ^ g2[tap_b[p-1]]);
            f1 = g1[3] ^ g1[10];
            f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
            for (int k = 10; k >= 2; k--) begin g1[k] = g1[k-1]; g2[k] = g2[k-1]; end
            g1[1] = f1;
            g2[1] = f2;
         end
      end
   endtask

   // Reference model: code phase is the integer part of the summed frequency words
   int          m_state;   // 0 idle, 1 fetch, 2 run
   int          m_prn;
   logic [63:0] m_acc;
   bit          m_bf, m_bb, m_cur, m_und, m_hs;
   bit          e_valid, e_chip, e_epoch, e_edge, e_ready;
   logic [15:0] e_sample;

   function automatic bit boundary_next();
      logic [63:0] s;
      s = m_acc + {32'd0, code_fcw_i};
      return (m_state == 2) && en_i && !rst && (s[63:32] != m_acc[63:32]) && (s[63:32] % 20460 == 0);
   endfunction

   task automatic model_step();
      logic [31:0] old_c, new_c;
      m_hs    = nav_valid_i && e_ready;
      e_epoch = 0;
      e_edge  = 0;
      if (rst) begin
         m_state = 0; m_acc = '0; m_bf = 0; m_bb = 0; m_cur = 0; m_und = 0;
      end else begin
         case (m_state)
            0: if (en_i && prn_sel_i >= 1 && prn_sel_i <= 32) begin
                  m_prn = int'(prn_sel_i); m_acc = '0; m_bf = 0; m_cur = 0; m_state = 1;
               end
            1: if (!en_i) m_state = 0;
               else if (m_hs) begin
                  m_cur = nav_bit_i; m_state = 2; e_epoch = 1; e_edge = 1;
               end
            default: if (!en_i) begin
                  m_state = 0; m_bf = 0;
               end else begin
                  old_c = m_acc[63:32];
                  m_acc = m_acc + {32'd0, code_fcw_i};
                  new_c = m_acc[63:32];
                  if (new_c != old_c && new_c % 1023 == 0) e_epoch = 1;
                  if (new_c != old_c && new_c % 20460 == 0) begin
                     e_edge = 1;
                     if (m_bf) begin m_cur = m_bb; m_bf = 0; end
                     else if (m_hs) m_cur = nav_bit_i;
                     else begin m_cur = 0; m_und = 1; end
                  end else if (m_hs) begin
                     m_bf = 1; m_bb = nav_bit_i;
                  end
               end
         endcase
      end
      e_valid  = (m_state == 2);
      e_ready  = (m_state == 1) || (m_state == 2 && !m_bf);
      e_chip   = e_valid ? code_tab[m_prn][m_acc[63:32] % 1023] : 1'b0;
      e_sample = !e_valid ? 16'h0000 : ((e_chip ^ m_cur) ? 16'hFF00 : 16'h0100);
   endtask

   int ep_prev, ep_last, edge_cnt;

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
      chk("outs{sample,valid,chip,epoch,edge,underrun,ready}",
          {10'd0, sample_o, sample_valid_o, chip_o, epoch_o, bit_edge_o, underrun_o, nav_ready_o},
          {10'd0, e_sample, e_valid, e_chip, e_epoch, e_edge, m_und, e_ready});
      if (epoch_o) begin ep_prev = ep_last; ep_last = cyc; end
      if (bit_edge_o) edge_cnt++;
   endtask

   bit offer [$];

   // nav modes: 0 random valid, 1 none, 2 only in boundary cycle, 3 bit queue, 4 always valid
   task automatic run(input int n, input int mode, input bit rand_prn);
      for (int i = 0; i < n; i++) begin
         case (mode)
            0: nav_valid_i = ($urandom_range(0, 3) != 0);
            1: nav_valid_i = 1'b0;
            2: nav_valid_i = boundary_next();
            3: begin
                  nav_valid_i = (offer.size() > 0) && ($urandom_range(0, 1) == 1);
                  nav_bit_i   = (offer.size() > 0) ? offer[0] : 1'b0;
               end
            default: nav_valid_i = 1'b1;
         endcase
         if (rand_prn && m_state == 2) prn_sel_i = 6'($urandom);
         tick();
         if (mode == 3 && m_hs && offer.size() > 0) void'(offer.pop_front());
      end
   endtask

   task automatic go_idle();
      en_i = 1'b0;
      run(2, 1, 1'b0);
   endtask

   initial begin
      logic [9:0]  first10;
      logic [31:0] fcw_keep;
      gen_codes();
      for (int p = 1; p <= 2; p++) begin
         for (int i = 0; i < 10; i++) first10[9-i] = code_tab[p][i];
         chk($sformatf("prn%0d_first10", p), {22'd0, first10}, (p == 1) ? 32'o1440 : 32'o1620);
      end

      rst = 1'b1; en_i = 1'b0; prn_sel_i = 6'd0; code_fcw_i = '0; nav_bit_i = 1'b0; nav_valid_i = 1'b0;
      m_state = 0; m_prn = 1; m_acc = '0; e_ready = 0;
      ep_prev = 0; ep_last = 0; edge_cnt = 0;
      run(3, 1, 1'b0);
      rst = 1'b0;

      // PRN1 at half chip rate across one full code period
      prn_sel_i = 6'd1; code_fcw_i = 32'h8000_0000; nav_bit_i = 1'b0; en_i = 1'b1;
      run(2100, 4, 1'b0);
      chk("epoch_period", 32'(ep_last - ep_prev), 32'd2046);

      // Sweep all PRNs with random code rates, a frozen stretch and ignored PRN changes
      for (int p = 1; p <= 32; p++) begin
         go_idle();
         prn_sel_i  = 6'(p);
         code_fcw_i = (p == 32) ? 32'hFFFF_FFFF : $urandom_range(32'h4000_0000, 32'hFFFF_FFFF);
         nav_bit_i  = 1'($urandom);
         en_i       = 1'b1;
         run(40, 0, 1'b1);
         fcw_keep = code_fcw_i; code_fcw_i = '0;
         run(10, 0, 1'b1);
         code_fcw_i = fcw_keep;
         run((p == 32) ? 1100 : 70, 0, 1'b1);
      end

      // Nav bits 1,0 prompt; bypass in the exact boundary cycle; then an underrun
      go_idle();
      prn_sel_i = 6'($urandom_range(1, 32)); code_fcw_i = 32'hFFFF_FFFF; en_i = 1'b1;
      edge_cnt = 0;
      offer.push_back(1'b1); offer.push_back(1'b0);
      run(20500, 3, 1'b1);
      nav_bit_i = 1'b1;
      run(20500, 2, 1'b1);
      chk("no_underrun_after_bypass", {31'd0, underrun_o}, 32'd0);
      run(20500, 1, 1'b1);
      chk("underrun_set", {31'd0, underrun_o}, 32'd1);
      chk("bit_edges", 32'(edge_cnt), 32'd4);

      // Disable mid-run, restart on PRN2 and fill the buffer
      en_i = 1'b0;
      run(3, 1, 1'b0);
      prn_sel_i = 6'd2; code_fcw_i = 32'h8000_0000; nav_bit_i = 1'b1; en_i = 1'b1;
      run(60, 4, 1'b0);

      // Reset with buffer full, then out-of-range PRNs hold the block idle
      rst = 1'b1;
      run(1, 4, 1'b0);
      chk("rst_ready", {31'd0, nav_ready_o}, 32'd0);
      chk("rst_underrun", {31'd0, underrun_o}, 32'd0);
      chk("rst_sample", {16'd0, sample_o}, 32'd0);
      rst = 1'b0; prn_sel_i = 6'd0;
      run(10, 4, 1'b0);
      chk("prn0_idle_ready", {31'd0, nav_ready_o}, 32'd0);
      prn_sel_i = 6'd33;
      run(10, 4, 1'b0);
      chk("prn33_idle_valid", {31'd0, sample_valid_o}, 32'd0);
      prn_sel_i = 6'd5;
      run(30, 4, 1'b0);
      chk("prn5_running", {31'd0, sample_valid_o}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
